// File: rtl/gate_tt_pkg.sv
// Shared types and widths for the gate truth-table sequencer.
package gate_tt_pkg;

    localparam int M_W   = 2;
    localparam int TT_W  = 4;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } tt_state_e;

    // {mismatch_seen, lowest mismatching minterm}; all zero when mis is clear
    function automatic logic [2:0] first_fail_f(input logic [TT_W-1:0] mis);
        logic [2:0] res;
        res = 3'b000;
        for (int i = TT_W - 1; i >= 0; i--) begin
            if (mis[i]) begin
                res = {1'b1, i[M_W-1:0]};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/tt_settle_counter.sv
// Settle-time counter: loads a count, decrements while enabled, flags zero.
module tt_settle_counter
    import gate_tt_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             en_i,
    output logic             term_o
);

    logic [CNT_W-1:0] count_q;

    // count register; load wins over decrement
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (en_i && (count_q != '0)) begin
            count_q <= count_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_q <= count_q;
        end
    end

    assign term_o = (count_q == '0);

endmodule

// File: rtl/gate_tt_sequencer.sv
// Sweeps the four minterms of an external 2-input gate and compares its table.
// Optional macro TT_FIRST_FAIL_EN adds the first_fail diagnostic output.
module gate_tt_sequencer
    import gate_tt_pkg::*;
#(
    parameter int unsigned SETTLE = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [TT_W-1:0] expected,
    input  logic            s_in,
    output logic            a_out,
    output logic            b_out,
    output logic            busy,
    output logic            done,
    output logic [TT_W-1:0] observed,
    output logic            pass
`ifdef TT_FIRST_FAIL_EN
    ,
    output logic [2:0]      first_fail
`endif
);

    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE - 1);
    localparam logic [M_W-1:0]   M_LAST    = {M_W{1'b1}};

    tt_state_e        state_q, state_d;
    logic [M_W-1:0]   m_q, m_d;
    logic [TT_W-1:0]  exp_q, exp_d;
    logic [TT_W-1:0]  obs_q, obs_d;
    logic             pass_q, pass_d;
    logic [2:0]       ff_q, ff_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             a_q, a_d;
    logic             b_q, b_d;
    logic             cnt_load_s, cnt_en_s, cnt_term_s;

    tt_settle_counter u_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (cnt_load_s),
        .load_val_i (SETTLE_LD),
        .en_i       (cnt_en_s),
        .term_o     (cnt_term_s)
    );

    // next-state, datapath updates and registered-output precomputation
    always_comb begin
        state_d    = state_q;
        m_d        = m_q;
        exp_d      = exp_q;
        obs_d      = obs_q;
        pass_d     = pass_q;
        ff_d       = ff_q;
        cnt_load_s = 1'b0;
        cnt_en_s   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    exp_d      = expected;
                    obs_d      = '0;
                    pass_d     = 1'b0;
                    ff_d       = 3'b000;
                    m_d        = '0;
                    cnt_load_s = 1'b1;
                    state_d    = ST_SETTLE;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_term_s) begin
                    state_d  = ST_SAMPLE;
                end else begin
                    cnt_en_s = 1'b1;
                end
            end
            ST_SAMPLE: begin
                obs_d[m_q] = s_in;
                if (m_q == M_LAST) begin
                    pass_d  = (obs_d == exp_q);
                    ff_d    = first_fail_f(obs_d ^ exp_q);
                    state_d = ST_DONE;
                end else begin
                    m_d        = m_q + {{(M_W-1){1'b0}}, 1'b1};
                    cnt_load_s = 1'b1;
                    state_d    = ST_SETTLE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_SETTLE) || (state_d == ST_SAMPLE);
        done_d = (state_d == ST_DONE);
        a_d    = busy_d & m_d[1];
        b_d    = busy_d & m_d[0];
    end

    // state and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            m_q     <= '0;
            exp_q   <= '0;
            obs_q   <= '0;
            pass_q  <= 1'b0;
            ff_q    <= 3'b000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            exp_q   <= exp_d;
            obs_q   <= obs_d;
            pass_q  <= pass_d;
            ff_q    <= ff_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    assign a_out    = a_q;
    assign b_out    = b_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign observed = obs_q;
    assign pass     = pass_q;
`ifdef TT_FIRST_FAIL_EN
    assign first_fail = ff_q;
`endif

endmodule

// File: doc/gate_tt_sequencer.md
GATE_TT_SEQUENCER -- requirements
Module: gate_tt_sequencer

Interface
REQ-001 SHALL have parameter SETTLE, default 1, giving wait cycles after driving a minterm before its output is sampled (legal range 1..15).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: request one truth-table sweep.
REQ-005 SHALL have port expected, input, 4 bits: reference table; bit m is the expected gate output for minterm m.
REQ-006 SHALL have port s_in, input, 1 bit: output of the 2-input gate under evaluation.
REQ-007 SHALL have ports a_out and b_out, output, 1 bit each: gate operands; a_out = m[1], b_out = m[0].
REQ-008 SHALL have port busy, output, 1 bit: sweep in progress.
REQ-009 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have port observed, output, 4 bits: captured table; bit m holds s_in sampled for minterm m.
REQ-011 SHALL have port pass, output, 1 bit: observed equals latched expected; valid from done onward.

Function
REQ-012 SHALL implement states IDLE, SETTLE, SAMPLE, DONE.
REQ-013 In IDLE with start=1, SHALL latch expected, clear observed, set m=0, and enter SETTLE; start is ignored in every other state.
REQ-014 SHALL hold a_out/b_out at minterm m for every SETTLE and SAMPLE cycle of that minterm.
REQ-015 SHALL stay in SETTLE exactly SETTLE cycles per minterm, then spend one SAMPLE cycle.
REQ-016 At the end of SAMPLE, SHALL write s_in into observed[m].
REQ-017 After SAMPLE, SHALL increment m and re-enter SETTLE when m<3; when m=3, SHALL enter DONE.
REQ-018 Each minterm SHALL take SETTLE+1 cycles; for start sampled at edge 0, busy SHALL be high for cycles 1..4*(SETTLE+1) and done high on cycle 4*(SETTLE+1)+1.
REQ-019 DONE SHALL last one cycle, then return to IDLE.
REQ-020 pass SHALL be registered at the DONE transition and held, together with observed, until the next accepted start.
REQ-021 a_out and b_out SHALL be 0 in IDLE and DONE.
REQ-022 A change on expected during a sweep SHALL have no effect.

Reset
REQ-023 reset=1 SHALL force, on the next edge, IDLE, m=0, a_out=b_out=busy=done=pass=0 and observed=4'b0000, including mid-sweep.
REQ-024 reset SHALL take priority over start on the same edge.

Configuration
REQ-025 With TT_FIRST_FAIL_EN defined, the block SHALL add output first_fail, 3 bits: bit 2 = mismatch seen, bits 1:0 = lowest mismatching minterm. first_fail SHALL update at the same edge as pass, clear on accepted start and on reset, and read 3'b000 when pass=1.
REQ-026 Without TT_FIRST_FAIL_EN, the first_fail port and its logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-027 State encoding, the minterm-index width (2) and the table width (4) SHALL live in shared package gate_tt_pkg.
REQ-028 The SETTLE/SAMPLE timing counter SHALL be sub-module tt_settle_counter (load, count-down, terminal flag).
REQ-029 The gate under evaluation SHALL stay external to this block and be connected only through a_out, b_out and s_in.

Verification
REQ-030 Gate s=~a&b, SETTLE=1, expected=4'b0010, start at cycle 0 -> busy high cycles 1..8, done=1 at cycle 9, observed=4'b0010, pass=1.
REQ-031 Same gate, expected=4'b1101 -> pass=0 at done; with TT_FIRST_FAIL_EN, first_fail=3'b100.
REQ-032 SETTLE=3, same gate, correct expected -> done at cycle 17; a_out/b_out step 00,01,10,11 every 4 cycles.
REQ-033 start pulsed at cycles 3 and 9 of a sweep -> both ignored; exactly one done pulse; expected changed mid-sweep does not alter pass.
REQ-034 reset asserted at cycle 4 -> from cycle 5 busy=0, a_out=b_out=0, observed=0; a new start at cycle 6 completes normally with done at cycle 15.
REQ-035 reset and start both high on the same edge -> block stays in IDLE with busy=0.
